// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals around the port arbiter.
// master: the environment (core driving requests, memory returning m_rdata).
// slave: the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // fetch port
  logic [15:0]       i_addr;
  logic              i_oe;
  logic [31:0]       i_rdata;
  logic              i_valid;
  // data port
  logic [31:0]       d_addr;
  logic [3:0]        d_oe;
  logic [3:0]        d_we;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              d_ready;
  // memory side
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_oe;
  logic [3:0]        m_we;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport master (
    output i_addr, i_oe, d_addr, d_oe, d_we, d_wdata, m_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid, d_ready,
    input  m_addr, m_oe, m_we, m_wdata
  );

  modport slave (
    input  i_addr, i_oe, d_addr, d_oe, d_we, d_wdata, m_rdata,
    output i_rdata, i_valid, d_rdata, d_valid, d_ready,
    output m_addr, m_oe, m_we, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data ports; data wins, starvation-guarded fetch.
// Latency: request at t -> m_* at t+1 -> valid pulse at t+1+LAT, plus one cycle per arbitration loss.
// Backpressure: a loser waits in a one-deep pend register; d_ready drops while the data pend is full.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int LAT       = 1,
  parameter int IWAIT_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int CW = (IWAIT_MAX < 2) ? 1 : $clog2(IWAIT_MAX + 1);

  // pending (lost) requests
  logic              i_pend;
  logic [15:0]       i_pend_addr;
  logic              d_pend;
  logic [31:0]       d_pend_addr;
  logic [3:0]        d_pend_oe;
  logic [3:0]        d_pend_we;
  logic [31:0]       d_pend_wdata;
  logic [CW-1:0]     starve_cnt;
  logic              d_ready_q;

  // registered memory command
  logic [ADDR_W-1:0] m_addr_q;
  logic [3:0]        m_oe_q;
  logic [3:0]        m_we_q;
  logic [31:0]       m_wdata_q;

  // in-flight read tags: stage k is valid k cycles after the command is on m_*
  logic [LAT:0]      tag_vld;
  logic [LAT:0]      tag_is_d;

  // candidate selection: a pend entry shadows any new request on that port
  logic              i_cand, d_cand, i_force, grant_i, grant_d;
  logic [15:0]       i_sel_addr;
  logic [31:0]       d_sel_addr, d_sel_wdata;
  logic [3:0]        d_sel_oe, d_sel_we;

  assign i_cand      = bus.i_oe | i_pend;
  assign d_cand      = (|bus.d_oe) | (|bus.d_we) | d_pend;
  assign i_sel_addr  = i_pend ? i_pend_addr  : bus.i_addr;
  assign d_sel_addr  = d_pend ? d_pend_addr  : bus.d_addr;
  assign d_sel_oe    = d_pend ? d_pend_oe    : bus.d_oe;
  assign d_sel_we    = d_pend ? d_pend_we    : bus.d_we;
  assign d_sel_wdata = d_pend ? d_pend_wdata : bus.d_wdata;

  // only a fetch that has already been waiting can be forced past data
  assign i_force = i_pend && (starve_cnt == CW'(IWAIT_MAX));
  assign grant_d = d_cand && !i_force;
  assign grant_i = i_cand && !grant_d;

  // arbitration state: pend capture, starvation counter, ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_pend       <= 1'b0;
      i_pend_addr  <= '0;
      d_pend       <= 1'b0;
      d_pend_addr  <= '0;
      d_pend_oe    <= '0;
      d_pend_we    <= '0;
      d_pend_wdata <= '0;
      starve_cnt   <= '0;
      d_ready_q    <= 1'b1;
    end else begin
      // a new request arriving while pend is full is dropped: pend keeps its contents
      if (i_cand && !grant_i) begin
        i_pend <= 1'b1;
        if (!i_pend) i_pend_addr <= bus.i_addr;
      end else begin
        i_pend <= 1'b0;
      end

      if (d_cand && !grant_d) begin
        d_pend <= 1'b1;
        if (!d_pend) begin
          d_pend_addr  <= bus.d_addr;
          d_pend_oe    <= bus.d_oe;
          d_pend_we    <= bus.d_we;
          d_pend_wdata <= bus.d_wdata;
        end
      end else begin
        d_pend <= 1'b0;
      end

      d_ready_q <= !(d_cand && !grant_d);

      if (grant_i)
        starve_cnt <= '0;
      else if (i_pend && starve_cnt != CW'(IWAIT_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // issue the winner onto the memory command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr_q  <= '0;
      m_oe_q    <= '0;
      m_we_q    <= '0;
      m_wdata_q <= '0;
    end else if (grant_d) begin
      m_addr_q  <= ADDR_W'(d_sel_addr);
      m_oe_q    <= d_sel_oe | d_sel_we;
      m_we_q    <= d_sel_we;
      m_wdata_q <= d_sel_wdata;
    end else if (grant_i) begin
      m_addr_q  <= ADDR_W'(i_sel_addr);
      m_oe_q    <= 4'b1111;
      m_we_q    <= 4'b0000;
    end else begin
      m_oe_q    <= 4'b0000;
      m_we_q    <= 4'b0000;
    end
  end

  // tag pipeline: reads only, so writes never produce a valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_is_d <= '0;
    end else begin
      tag_vld  <= {tag_vld[LAT-1:0],  (grant_d ? (d_sel_we == 4'b0000) : grant_i)};
      tag_is_d <= {tag_is_d[LAT-1:0], grant_d};
    end
  end

  assign bus.m_addr  = m_addr_q;
  assign bus.m_oe    = m_oe_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign bus.i_valid = tag_vld[LAT] & ~tag_is_d[LAT];
  assign bus.d_valid = tag_vld[LAT] &  tag_is_d[LAT];
endmodule
